// File: rtl/hdb3_decode.sv
// HDB3 line-code decoder: strips 000V / B00V substitutions from ternary symbols,
// flags illegal codes and zero runs, and keeps saturating violation / error counts.
module hdb3_decode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             viol_pulse,
  output logic             code_err,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [3:0]       sr_q, sr_d;
  logic [2:0]       fill_q, fill_d;
  logic [1:0]       zrun_q, zrun_d;
  logic             last_pol_q, last_pol_d;
  logic             have_pol_q, have_pol_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             viol_q, viol_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic is_pulse, pol, is_illegal, is_viol, is_err;

  always_comb begin
    is_pulse   = (sym_in == 2'b01) || (sym_in == 2'b10);
    pol        = (sym_in == 2'b01);
    is_illegal = (sym_in == 2'b11);
    is_viol    = is_pulse && have_pol_q && (pol == last_pol_q);
    // An illegal symbol that also completes a zero run still counts as one error.
    is_err     = is_illegal || (!is_pulse && (zrun_q == 2'd3));
  end

  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    zrun_d      = zrun_q;
    last_pol_d  = last_pol_q;
    have_pol_d  = have_pol_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    viol_d      = 1'b0;
    err_d       = 1'b0;
    viol_cnt_d  = viol_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (sym_valid) begin
      if (fill_q == 3'd4) begin
        bit_valid_d = 1'b1;
        bit_out_d   = sr_q[3];
      end else begin
        fill_d = fill_q + 3'd1;
      end

      // A violation wipes V and the three positions before it (000V and B00V alike).
      if (is_viol) begin
        sr_d = 4'b0000;
      end else begin
        sr_d = {sr_q[2:0], is_pulse};
      end

      if (is_pulse) begin
        last_pol_d = pol;
        have_pol_d = 1'b1;
        zrun_d     = 2'd0;
      end else if (zrun_q != 2'd3) begin
        zrun_d = zrun_q + 2'd1;
      end

      viol_d = is_viol;
      err_d  = is_err;

      if (is_viol && (viol_cnt_q != {CNT_W{1'b1}})) begin
        viol_cnt_d = viol_cnt_q + 1'b1;
      end
      if (is_err && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= 4'b0000;
      fill_q      <= 3'd0;
      zrun_q      <= 2'd0;
      last_pol_q  <= 1'b0;
      have_pol_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      viol_q      <= 1'b0;
      err_q       <= 1'b0;
      viol_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      zrun_q      <= zrun_d;
      last_pol_q  <= last_pol_d;
      have_pol_q  <= have_pol_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      viol_q      <= viol_d;
      err_q       <= err_d;
      viol_cnt_q  <= viol_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign viol_pulse = viol_q;
  assign code_err   = err_q;
  assign viol_cnt   = viol_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hdb3_decode.sv
// Directed bench for hdb3_decode: expected bits queued per sequence, popped on bit_valid.
module tb_hdb3_decode;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_in = 2'b00;
  logic        bit_out, bit_valid, viol_pulse, code_err;
  logic [15:0] viol_cnt, err_cnt;

  logic        sv2 = 1'b0;
  logic [1:0]  si2 = 2'b00;
  logic        bit_out2, bit_valid2, viol2, err2;
  logic [1:0]  viol_cnt2, err_cnt2;

  int checks = 0;
  int failures = 0;

  logic       exp_bits[$];
  logic [1:0] seq_sym[$];
  bit         seq_v[$];
  bit         seq_e[$];

  always #5 clk = ~clk;

  hdb3_decode #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_in(sym_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .viol_pulse(viol_pulse),
    .code_err(code_err), .viol_cnt(viol_cnt), .err_cnt(err_cnt)
  );

  hdb3_decode #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sym_valid(sv2), .sym_in(si2),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .viol_pulse(viol2),
    .code_err(err2), .viol_cnt(viol_cnt2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every bit the DUT produces must match the head of the expected queue.
  always @(negedge clk) begin
    if (bit_valid !== 1'b0) begin
      checks++;
      assert (exp_bits.size() > 0) else begin
        failures++;
        $error("FAIL bit_unexpected observed=bit_valid=%b expected=no bit", bit_valid);
      end
      if (exp_bits.size() > 0) chk("bit_out", {31'd0, bit_out}, {31'd0, exp_bits.pop_front()});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle strobes", {29'd0, bit_valid, viol_pulse, code_err}, 32'd0);
    end
  endtask

  task automatic send(input logic [1:0] s, input bit ev, input bit ee, input string tag);
    sym_valid = 1'b1;
    sym_in    = s;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    chk({tag, " viol_pulse"}, {31'd0, viol_pulse}, {31'd0, ev});
    chk({tag, " code_err"}, {31'd0, code_err}, {31'd0, ee});
  endtask

  task automatic run_seq(input string tag, input bit gapped);
    foreach (seq_sym[i]) begin
      if (gapped) idle($urandom_range(0, 3));
      send(seq_sym[i], seq_v[i], seq_e[i], tag);
    end
    idle(1);
    chk({tag, " drained"}, exp_bits.size(), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " strobes"}, {29'd0, bit_valid, viol_pulse, code_err}, 32'd0);
    chk({tag, " bit_out"}, {31'd0, bit_out}, 32'd0);
    chk({tag, " viol_cnt"}, {16'd0, viol_cnt}, 32'd0);
    chk({tag, " err_cnt"}, {16'd0, err_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero_outputs("reset");
    idle(2);
    rst = 1'b0;
    exp_bits.delete();
  endtask

  task automatic load_ami();
    seq_sym  = '{P, Z, N, P, Z, N, Z, Z, P, Z, Z, Z, Z};
    seq_v    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    seq_e    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp_bits = '{1, 0, 1, 1, 0, 1, 0, 0, 1};
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held while symbols toggle: nothing may leak out.
    for (int i = 0; i < 8; i++) begin
      sym_valid = 1'($urandom);
      sym_in    = 2'($urandom);
      @(posedge clk);
      #1;
      check_zero_outputs("hold_rst");
    end
    sym_valid = 1'b0;
    rst = 1'b0;

    load_ami();
    run_seq("ami", 1'b0);
    chk("ami viol_cnt", {16'd0, viol_cnt}, 32'd0);
    chk("ami err_cnt", {16'd0, err_cnt}, 32'd1);

    do_reset();
    seq_sym  = '{P, Z, Z, Z, P, N, Z, Z, Z, Z};
    seq_v    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    seq_e    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp_bits = '{1, 0, 0, 0, 0, 1};
    run_seq("000v", 1'b0);
    chk("000v viol_cnt", {16'd0, viol_cnt}, 32'd1);
    chk("000v err_cnt", {16'd0, err_cnt}, 32'd1);

    do_reset();
    seq_sym  = '{P, N, Z, Z, N, P, Z, Z, Z, Z};
    seq_v    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    seq_e    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    exp_bits = '{1, 0, 0, 0, 0, 1};
    run_seq("b00v", 1'b0);
    chk("b00v viol_cnt", {16'd0, viol_cnt}, 32'd1);

    // Illegal code, then a five-zero run, then an illegal code at zrun==3.
    do_reset();
    seq_sym  = '{P, X, N, Z, Z, Z, Z, Z, X};
    seq_v    = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    seq_e    = '{0, 1, 0, 0, 0, 0, 1, 1, 1};
    exp_bits = '{1, 0, 1, 0, 0};
    run_seq("err", 1'b0);
    chk("err err_cnt", {16'd0, err_cnt}, 32'd4);
    chk("err viol_cnt", {16'd0, viol_cnt}, 32'd0);

    do_reset();
    load_ami();
    run_seq("gapped", 1'b1);
    chk("gapped err_cnt", {16'd0, err_cnt}, 32'd1);

    // Mid-stream reset: prior symbols and polarity must be forgotten.
    do_reset();
    seq_sym  = '{P, Z, N};
    seq_v    = '{0, 0, 0};
    seq_e    = '{0, 0, 0};
    run_seq("pre_rst", 1'b0);
    #2 rst = 1'b1;
    #1 check_zero_outputs("mid_rst");
    idle(1);
    rst = 1'b0;
    seq_sym  = '{N, P, Z, N, Z, Z, Z, Z};
    seq_v    = '{0, 0, 0, 0, 0, 0, 0, 0};
    seq_e    = '{0, 0, 0, 0, 0, 0, 0, 1};
    exp_bits = '{1, 1, 0, 1};
    run_seq("post_rst", 1'b0);
    chk("post_rst viol_cnt", {16'd0, viol_cnt}, 32'd0);

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 6; i++) begin
      sv2 = 1'b1;
      si2 = P;
      @(posedge clk);
      #1;
      sv2 = 1'b0;
      chk("sat viol_pulse", {31'd0, viol2}, (i > 0) ? 32'd1 : 32'd0);
    end
    chk("sat viol_cnt", {30'd0, viol_cnt2}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      sv2 = 1'b1;
      si2 = X;
      @(posedge clk);
      #1;
      sv2 = 1'b0;
      chk("sat code_err", {31'd0, err2}, 32'd1);
    end
    chk("sat err_cnt", {30'd0, err_cnt2}, 32'd3);
    chk("sat viol_cnt hold", {30'd0, viol_cnt2}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
